// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types, defaults and helpers for the TDM serial link
package tdm_pkg;

    typedef enum logic {HUNT, RUN} state_t;

    localparam int DEF_N_CH   = 4;
    localparam int DEF_SLOT_W = 8;
    localparam int FRAME_BITS = DEF_N_CH * DEF_SLOT_W;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/tdm_slot_deser.sv
// tdm_slot_deser: MSB-first slot shift register with wrapping bit counter
module tdm_slot_deser
    import tdm_pkg::*;
#(
    parameter int SLOT_W = DEF_SLOT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       din,
    input  logic                       clear,
    output logic [SLOT_W-1:0]          word,
    output logic                       word_done,
    output logic [clog2(SLOT_W)-1:0]   bit_cnt
);

    localparam int BW = clog2(SLOT_W);

    logic [SLOT_W-2:0] shreg;

    assign word      = {shreg, din};
    assign word_done = en && !clear && bit_cnt == BW'(SLOT_W - 1);

    // shift one bit per enabled sample; clear restarts with this sample as bit 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (en) begin
            shreg   <= clear ? (SLOT_W-1)'(din) : word[SLOT_W-2:0];
            bit_cnt <= clear ? BW'(1) : word_done ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: frame-aligned TDM deserialiser with double-buffered channel words
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int SLOT_W = DEF_SLOT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     din,
    input  logic                     fsync,
    output logic [N_CH*SLOT_W-1:0]   ch_data,
    output logic                     frame_valid,
    output logic                     sync_err,
    output logic                     locked
);

    localparam int BW = clog2(SLOT_W);
    localparam int SW = clog2(N_CH);

    state_t                  state, state_n;
    logic                    shift, clear, err, at_start, last;
    logic [SLOT_W-1:0]       word;
    logic                    word_done;
    logic [BW-1:0]           bit_cnt;
    logic [SW-1:0]           slot_cnt;
    logic [SLOT_W-1:0]       staging [N_CH];
    logic [N_CH*SLOT_W-1:0]  frame_next;

    tdm_slot_deser #(.SLOT_W(SLOT_W)) u_deser (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (shift),
        .din       (din),
        .clear     (clear),
        .word      (word),
        .word_done (word_done),
        .bit_cnt   (bit_cnt)
    );

    assign at_start = bit_cnt == '0 && slot_cnt == '0;
    assign last     = word_done && slot_cnt == SW'(N_CH - 1);
    assign locked   = state == RUN;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_n;
    end

    // alignment decisions: acquire, verify frame start, resync on early fsync
    always_comb begin
        state_n = state;
        shift   = 1'b0;
        clear   = 1'b0;
        err     = 1'b0;
        if (en) begin
            if (state == HUNT) begin
                shift   = fsync;
                clear   = fsync;
                state_n = fsync ? RUN : HUNT;
            end else if (at_start && !fsync) begin
                err     = 1'b1;
                state_n = HUNT;
            end else begin
                shift = 1'b1;
                clear = fsync && !at_start;
                err   = fsync && !at_start;
            end
        end
    end

    // full frame image: staged slots plus the word completing this edge
    always_comb begin
        frame_next = '0;
        for (int k = 0; k < N_CH; k++)
            frame_next[k*SLOT_W +: SLOT_W] = (k == N_CH - 1) ? word : staging[k];
    end

    // slot counter, staging buffer, output register and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            ch_data     <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            for (int k = 0; k < N_CH; k++) staging[k] <= '0;
        end else begin
            frame_valid <= last;
            sync_err    <= err;
            if (clear) begin
                slot_cnt <= '0;
            end else if (word_done) begin
                staging[slot_cnt] <= word;
                slot_cnt          <= last ? '0 : slot_cnt + 1'b1;
            end
            if (last) ch_data <= frame_next;
        end
    end

endmodule
